// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the PC, drives IMem every cycle and queues
// each returned instruction with its PC for the core to drain via valid/ready.
// A redirect from the core flushes the queue and reloads the PC.
module inst_fetch_queue #(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                    in_Clk,
  input  logic                    in_Rst_N,
  output logic [DATA_WIDTH-1:0]   out_inst_addr,
  input  logic [31:0]             in_inst,
  input  logic                    in_redirect,
  input  logic [DATA_WIDTH-1:0]   in_redirect_addr,
  output logic                    out_valid,
  input  logic                    in_ready,
  output logic [31:0]             out_inst,
  output logic [DATA_WIDTH-1:0]   out_pc,
  output logic [$clog2(DEPTH):0]  out_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] pc_q;
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [CNT_W-1:0]      count_q;

  logic [DATA_WIDTH-1:0] pc_mem   [DEPTH];
  logic [31:0]           inst_mem [DEPTH];

  logic pop;
  logic fetch;

  // Handshake and enqueue qualifiers; redirect suppresses any enqueue
  always_comb begin
    pop   = out_valid & in_ready;
    fetch = ~in_redirect & ((count_q < CNT_W'(DEPTH)) | pop);
  end

  // PC, pointers and occupancy; redirect wins over fetch and pop
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (in_redirect) begin
      pc_q    <= in_redirect_addr & ~DATA_WIDTH'(3);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (fetch) begin
        pc_q   <= pc_q + DATA_WIDTH'(4);
        tail_q <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(fetch) - CNT_W'(pop);
    end
  end

  // Queue storage; contents need no reset since count gates visibility
  always_ff @(posedge in_Clk) begin
    if (fetch) begin
      pc_mem[tail_q]   <= pc_q;
      inst_mem[tail_q] <= in_inst;
    end
  end

  // Head entry and status presented straight from state
  always_comb begin
    out_inst_addr = pc_q;
    out_valid     = (count_q != '0);
    out_inst      = inst_mem[head_q];
    out_pc        = pc_mem[head_q];
    out_count     = count_q;
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: an IMem model returns
// 0x13 + word index, and a scoreboard of expected PCs is consumed on
// every handshake.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] inst_addr;
  logic [31:0] inst;
  logic        redirect = 1'b0;
  logic [63:0] redirect_addr = '0;
  logic        valid;
  logic        ready = 1'b0;
  logic [31:0] head_inst;
  logic [63:0] head_pc;
  logic [2:0]  count;

  logic        rst_w_n = 1'b0;
  logic [63:0] inst_addr_w;
  logic [31:0] inst_w;
  logic        ready_w = 1'b0;
  logic        valid_w;
  logic [31:0] head_inst_w;
  logic [63:0] head_pc_w;
  logic [2:0]  count_w;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [63:0] a);
    logic [63:0] w;
    w = a >> 2;
    return 32'h0000_0013 + w[31:0];
  endfunction

  assign inst   = imem(inst_addr);
  assign inst_w = imem(inst_addr_w);

  inst_fetch_queue #(.DATA_WIDTH(64), .DEPTH(4), .RESET_PC(64'h0)) dut (
    .in_Clk(clk), .in_Rst_N(rst_n), .out_inst_addr(inst_addr), .in_inst(inst),
    .in_redirect(redirect), .in_redirect_addr(redirect_addr),
    .out_valid(valid), .in_ready(ready), .out_inst(head_inst),
    .out_pc(head_pc), .out_count(count)
  );

  inst_fetch_queue #(.DATA_WIDTH(64), .DEPTH(4), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut_w (
    .in_Clk(clk), .in_Rst_N(rst_w_n), .out_inst_addr(inst_addr_w), .in_inst(inst_w),
    .in_redirect(1'b0), .in_redirect_addr(64'h0),
    .out_valid(valid_w), .in_ready(ready_w), .out_inst(head_inst_w),
    .out_pc(head_pc_w), .out_count(count_w)
  );

  // One cycle: at the falling edge, score the head if it will be consumed at
  // the coming rising edge, then drive the inputs for that edge.
  task automatic drive(input logic rdy, input logic redir, input logic [63:0] raddr);
    logic [63:0] e;
    @(negedge clk);
    if (valid && rdy) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_head: got pc %h, scoreboard empty", head_pc);
      end else begin
        e = exp_q.pop_front();
        if (head_pc !== e || head_inst !== imem(e)) begin
          miscompares++;
          $display("FAIL head_entry: got pc %h inst %h, expected pc %h inst %h",
                   head_pc, head_inst, e, imem(e));
        end
      end
    end
    ready = rdy;
    redirect = redir;
    redirect_addr = raddr;
  endtask

  task automatic push_seq(input logic [63:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 64'(4 * i));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    ready = 1'b0;
    redirect = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", valid); end
    vectors++;
    if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
    vectors++;
    if (inst_addr !== 64'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", inst_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    push_seq(64'h0, 40);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 64'h0);
      vectors++;
      if (count !== 3'd1) begin miscompares++; $display("FAIL stream_count: got %0d expected 1", count); end
      vectors++;
      if (inst_addr !== 64'(4 * (k + 1))) begin
        miscompares++; $display("FAIL stream_addr: got %h expected %h", inst_addr, 64'(4 * (k + 1)));
      end
    end
  endtask

  task automatic test_backpressure();
    int c;
    apply_reset();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 1'b0, 64'h0);
      c = (k < 4) ? k : 4;
      vectors++;
      if (count !== 3'(c)) begin miscompares++; $display("FAIL bp_count: got %0d expected %0d", count, c); end
      vectors++;
      if (inst_addr !== 64'(4 * c)) begin
        miscompares++; $display("FAIL bp_addr: got %h expected %h", inst_addr, 64'(4 * c));
      end
    end
    push_seq(64'h0, 40);
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 1'b0, 64'h0);
      vectors++;
      if (count !== 3'd4) begin miscompares++; $display("FAIL drain_count: got %0d expected 4", count); end
    end
  endtask

  task automatic test_redirect_full();
    drive(1'b0, 1'b0, 64'h0);
    vectors++;
    if (count !== 3'd4) begin miscompares++; $display("FAIL redir_full_pre: got %0d expected 4", count); end
    drive(1'b0, 1'b1, 64'h100);
    exp_q.delete();
    drive(1'b0, 1'b0, 64'h0);
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush_valid: got %b expected 0", valid); end
    vectors++;
    if (inst_addr !== 64'h100) begin miscompares++; $display("FAIL redir_addr: got %h expected 100", inst_addr); end
    push_seq(64'h100, 20);
    drive(1'b0, 1'b0, 64'h0);
    vectors++;
    if (valid !== 1'b1 || head_pc !== 64'h100) begin
      miscompares++; $display("FAIL redir_target_head: got valid %b pc %h expected 1 100", valid, head_pc);
    end
    for (int k = 0; k < 6; k++) drive(1'b1, 1'b0, 64'h0);
  endtask

  task automatic test_redirect_pop();
    drive(1'b1, 1'b1, 64'h203);
    push_seq(64'h200, 20);
    drive(1'b1, 1'b0, 64'h0);
    vectors++;
    if (valid !== 1'b0 || count !== 3'd0) begin
      miscompares++; $display("FAIL redir_pop_flush: got valid %b count %0d expected 0 0", valid, count);
    end
    vectors++;
    if (inst_addr !== 64'h200) begin miscompares++; $display("FAIL redir_pop_addr: got %h expected 200", inst_addr); end
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 64'h0);
    // back-to-back redirects: the second target wins
    drive(1'b0, 1'b1, 64'h300);
    drive(1'b0, 1'b1, 64'h404);
    push_seq(64'h404, 20);
    drive(1'b0, 1'b0, 64'h0);
    vectors++;
    if (inst_addr !== 64'h404 || valid !== 1'b0) begin
      miscompares++; $display("FAIL redir_b2b: got addr %h valid %b expected 404 0", inst_addr, valid);
    end
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 64'h0);
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 64'h0);
    vectors++;
    if (count !== 3'd3) begin miscompares++; $display("FAIL async_pre_count: got %0d expected 3", count); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (valid !== 1'b0 || count !== 3'd0) begin
      miscompares++; $display("FAIL async_reset: got valid %b count %0d expected 0 0", valid, count);
    end
    vectors++;
    if (inst_addr !== 64'h0) begin miscompares++; $display("FAIL async_addr: got %h expected 0", inst_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    push_seq(64'h0, 20);
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, 64'h0);
    vectors++;
    if (count !== 3'd1) begin miscompares++; $display("FAIL async_restart_count: got %0d expected 1", count); end
  endtask

  task automatic test_wrap();
    logic [63:0] exp_w[$];
    logic [63:0] e;
    exp_w = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4, 64'h8, 64'hC};
    @(negedge clk);
    rst_w_n = 1'b1;
    ready_w = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vectors++;
      if (!valid_w) begin
        miscompares++; $display("FAIL wrap_valid: got %b expected 1", valid_w);
      end else begin
        e = exp_w.pop_front();
        if (head_pc_w !== e || head_inst_w !== imem(e)) begin
          miscompares++;
          $display("FAIL wrap_head: got pc %h inst %h, expected pc %h inst %h",
                   head_pc_w, head_inst_w, e, imem(e));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_pop();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
